processador_mips_multi: RTL and testbench

PROCESSADOR_MIPS_MULTI -- requirements
Module: processador_mips_multi

---
 rtl/mips_pkg.sv | 70 +++++++
 rtl/mips_multi_ctrl.sv | 88 ++++++++
 rtl/regfile.sv | 25 ++
 rtl/ula.sv | 23 ++
 rtl/processador_mips_multi.sv | 138 +++++++++++++
 tb/tb_processador_mips_multi.sv | 231 +++++++++++++++++++++++
 6 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS core: opcodes, functs, FSM states, ALU ops.
package mips_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd7
   } state_e;

   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL
   } alu_op_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   function automatic logic op_legal(input logic [5:0] op, input logic en_jal);
      case (op)
         OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
         OP_ANDI, OP_ORI, OP_LW, OP_SW: return 1'b1;
         OP_JAL:  return en_jal;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic funct_legal(input logic [5:0] fn);
      return fn inside {FN_SLL, FN_SRL, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
   endfunction

   function automatic alu_op_e alu_sel(input logic [5:0] op, input logic [5:0] fn);
      if (op == OP_RTYPE) begin
         case (fn)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            FN_SLL:  return ALU_SLL;
            FN_SRL:  return ALU_SRL;
            default: return ALU_ADD;
         endcase
      end
      case (op)
         OP_SLTI: return ALU_SLT;
         OP_ANDI: return ALU_AND;
         OP_ORI:  return ALU_OR;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/mips_multi_ctrl.sv
// Multicycle sequencer: state register, retire pulse/counter and halt flag.
module mips_multi_ctrl
   import mips_pkg::*;
#(
   parameter bit ENABLE_JAL = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [5:0]  opcode_i,
   input  logic [5:0]  funct_i,
   input  logic        mem_ready_i,
   output state_e      state_o,
   output logic        instr_done_o,
   output logic [31:0] instr_count_o,
   output logic        halted_o
);
   state_e      state_q;
   logic        done_q;
   logic        halted_q;
   logic [31:0] count_q;
   logic        is_jump;
   logic        retire_c;

   assign is_jump = opcode_i inside {OP_BEQ, OP_BNE, OP_J, OP_JAL};

   // Retirement happens on every transition back into FETCH.
   always_comb begin
      retire_c = 1'b0;
      case (state_q)
         S_EXEC:  retire_c = is_jump;
         S_MEM:   retire_c = mem_ready_i && (opcode_i == OP_SW);
         S_WB:    retire_c = 1'b1;
         default: retire_c = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_FETCH;
         done_q   <= 1'b0;
         halted_q <= 1'b0;
         count_q  <= 32'h0;
      end else begin
         done_q <= retire_c;
         if (retire_c) count_q <= count_q + 32'd1;
         case (state_q)
            S_FETCH:  if (mem_ready_i) state_q <= S_DECODE;
            S_DECODE: begin
               if (op_legal(opcode_i, ENABLE_JAL)) begin
                  state_q <= S_EXEC;
               end else begin
                  state_q  <= S_HALT;
                  halted_q <= 1'b1;
               end
            end
            S_EXEC: begin
               if (is_jump) begin
                  state_q <= S_FETCH;
               end else if (opcode_i inside {OP_LW, OP_SW}) begin
                  state_q <= S_MEM;
               end else if ((opcode_i != OP_RTYPE) || funct_legal(funct_i)) begin
                  state_q <= S_WB;
               end else begin
                  state_q  <= S_HALT;
                  halted_q <= 1'b1;
               end
            end
            S_MEM: begin
               if (mem_ready_i) begin
                  if (opcode_i == OP_SW) state_q <= S_FETCH;
                  else                   state_q <= S_WB;
               end
            end
            S_WB:    state_q <= S_FETCH;
            S_HALT:  state_q <= S_HALT;
            default: begin
               state_q  <= S_HALT;
               halted_q <= 1'b1;
            end
         endcase
      end
   end

   assign state_o       = state_q;
   assign instr_done_o  = done_q;
   assign instr_count_o = count_q;
   assign halted_o      = halted_q;
endmodule

// File: rtl/regfile.sv
// 32x32 register file, two async read ports, one write port; R0 hardwired to zero.
module regfile (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] wdata_i,
   input  logic [4:0]  raddr_a_i,
   input  logic [4:0]  raddr_b_i,
   output logic [31:0] rdata_a_o,
   output logic [31:0] rdata_b_o
);
   logic [31:0] regs_q [32];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= 32'h0;
      end else if (we_i && (waddr_i != 5'd0)) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = (raddr_a_i == 5'd0) ? 32'h0 : regs_q[raddr_a_i];
   assign rdata_b_o = (raddr_b_i == 5'd0) ? 32'h0 : regs_q[raddr_b_i];
endmodule

// File: rtl/ula.sv
// Combinational ALU; shifts take their amount from a_i[4:0] and shift b_i.
module ula
   import mips_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  alu_op_e     op_i,
   output logic [31:0] res_o
);
   always_comb begin
      res_o = 32'h0;
      case (op_i)
         ALU_ADD: res_o = a_i + b_i;
         ALU_SUB: res_o = a_i - b_i;
         ALU_AND: res_o = a_i & b_i;
         ALU_OR:  res_o = a_i | b_i;
         ALU_SLT: res_o = {31'h0, $signed(a_i) < $signed(b_i)};
         ALU_SLL: res_o = b_i << a_i[4:0];
         ALU_SRL: res_o = b_i >> a_i[4:0];
         default: res_o = 32'h0;
      endcase
   end
endmodule

// File: rtl/processador_mips_multi.sv
// Multicycle MIPS subset core with a single req/ready memory port shared by fetch and load/store.
module processador_mips_multi
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned ADDR_W     = 32,
   parameter bit          ENABLE_JAL = 1'b1
) (
   input  logic              clock,
   input  logic              reset_global,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic [31:0]       PC_out,
   output logic [31:0]       ALU_out,
   output logic [2:0]        state_out,
   output logic              instr_done,
   output logic [31:0]       instr_count,
   output logic              halted
);
   state_e      state;
   logic [31:0] pc_q, ir_q, a_q, b_q, mdr_q, alu_q;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [31:0] imm_sext, imm_zext, rd_a, rd_b;
   logic [31:0] ula_a, ula_b, ula_y, addr_full;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   assign opcode   = ir_q[31:26];
   assign rs       = ir_q[25:21];
   assign rt       = ir_q[20:16];
   assign rd       = ir_q[15:11];
   assign shamt    = ir_q[10:6];
   assign funct    = ir_q[5:0];
   assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
   assign imm_zext = {16'h0, ir_q[15:0]};

   mips_multi_ctrl #(.ENABLE_JAL(ENABLE_JAL)) u_ctrl (
      .clk_i         (clock),
      .rst_i         (reset_global),
      .opcode_i      (opcode),
      .funct_i       (funct),
      .mem_ready_i   (mem_ready),
      .state_o       (state),
      .instr_done_o  (instr_done),
      .instr_count_o (instr_count),
      .halted_o      (halted)
   );

   regfile u_rf (
      .clk_i     (clock),
      .rst_i     (reset_global),
      .we_i      (rf_we),
      .waddr_i   (rf_waddr),
      .wdata_i   (rf_wdata),
      .raddr_a_i (rs),
      .raddr_b_i (rt),
      .rdata_a_o (rd_a),
      .rdata_b_o (rd_b)
   );

   assign ula_a = ((opcode == OP_RTYPE) && (funct inside {FN_SLL, FN_SRL})) ? 32'(shamt) : a_q;
   assign ula_b = (opcode == OP_RTYPE) ? b_q :
                  (opcode inside {OP_ANDI, OP_ORI}) ? imm_zext : imm_sext;

   ula u_ula (
      .a_i   (ula_a),
      .b_i   (ula_b),
      .op_i  (alu_sel(opcode, funct)),
      .res_o (ula_y)
   );

   // Single write port: jal links in EXEC, everything else writes back in WB.
   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = rt;
      rf_wdata = alu_q;
      if ((state == S_EXEC) && (opcode == OP_JAL)) begin
         rf_we    = 1'b1;
         rf_waddr = 5'd31;
         rf_wdata = pc_q;
      end else if (state == S_WB) begin
         rf_we    = 1'b1;
         rf_waddr = (opcode == OP_RTYPE) ? rd : rt;
         rf_wdata = (opcode == OP_LW) ? mdr_q : alu_q;
      end
   end

   always_ff @(posedge clock or posedge reset_global) begin
      if (reset_global) begin
         pc_q  <= RESET_PC;
         ir_q  <= 32'h0;
         a_q   <= 32'h0;
         b_q   <= 32'h0;
         mdr_q <= 32'h0;
         alu_q <= 32'h0;
      end else begin
         case (state)
            S_FETCH: begin
               if (mem_ready) begin
                  ir_q <= mem_rdata;
                  pc_q <= pc_q + 32'd4;
               end
            end
            S_DECODE: begin
               a_q   <= rd_a;
               b_q   <= rd_b;
               alu_q <= pc_q + {imm_sext[29:0], 2'b00};
            end
            S_EXEC: begin
               case (opcode)
                  OP_BEQ:       if (a_q == b_q) pc_q <= alu_q;
                  OP_BNE:       if (a_q != b_q) pc_q <= alu_q;
                  OP_J, OP_JAL: pc_q <= {pc_q[31:28], ir_q[25:0], 2'b00};
                  default:      if ((opcode != OP_RTYPE) || funct_legal(funct)) alu_q <= ula_y;
               endcase
            end
            S_MEM: if (mem_ready && (opcode == OP_LW)) mdr_q <= mem_rdata;
            default: ;
         endcase
      end
   end

   // Bus outputs derive from registers that are frozen while a transfer waits.
   assign addr_full = (state == S_MEM) ? alu_q : pc_q;
   assign mem_req   = ((state == S_FETCH) || (state == S_MEM)) && !reset_global;
   assign mem_we    = (state == S_MEM) && (opcode == OP_SW);
   assign mem_addr  = {addr_full[ADDR_W-1:2], 2'b00};
   assign mem_wdata = b_q;
   assign PC_out    = pc_q;
   assign ALU_out   = alu_q;
   assign state_out = state;
endmodule

// File: tb/tb_processador_mips_multi.sv
// Directed bench for processador_mips_multi with a unified word memory model.
module tb_processador_mips_multi;
   logic        clock = 1'b0;
   logic        reset_global = 1'b1;
   logic        mem_req, mem_we, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [31:0] PC_out, ALU_out, instr_count;
   logic [2:0]  state_out;
   logic        instr_done, halted;

   logic [31:0] mem [256];
   logic [31:0] last_waddr, last_wdata;
   int          n_writes;
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clock = ~clock;

   processador_mips_multi #(.RESET_PC(32'h0), .ADDR_W(32), .ENABLE_JAL(1'b1)) dut (
      .clock        (clock),
      .reset_global (reset_global),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_ready    (mem_ready),
      .PC_out       (PC_out),
      .ALU_out      (ALU_out),
      .state_out    (state_out),
      .instr_done   (instr_done),
      .instr_count  (instr_count),
      .halted       (halted)
   );

   assign mem_rdata = mem[mem_addr[9:2]];

   always @(posedge clock) begin
      if (mem_req && mem_ready && mem_we) begin
         mem[mem_addr[9:2]] = mem_wdata;
         last_waddr = mem_addr;
         last_wdata = mem_wdata;
         n_writes++;
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
      return {6'h00, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
      return {op, tgt};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Hold reset, clear memory; caller loads a program then calls release_reset.
   task automatic hold_reset();
      reset_global = 1'b1;
      mem_ready    = 1'b1;
      n_writes     = 0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      @(posedge clock);
      #1;
   endtask

   task automatic release_reset();
      @(negedge clock);
      reset_global = 1'b0;
      #1;
      check("first_req", 32'(mem_req), 32'd1);
      check("first_addr", mem_addr, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state and zero-wait ALU sequence
      hold_reset();
      check("rst_state", 32'(state_out), 32'd0);
      check("rst_pc", PC_out, 32'h0);
      check("rst_alu", ALU_out, 32'h0);
      check("rst_count", instr_count, 32'h0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_req", 32'(mem_req), 32'd0);
      mem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
      mem[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'd7);
      mem[2]  = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
      mem[3]  = enc_r(5'd1, 5'd2, 5'd4, 5'd0, 6'h22);
      mem[4]  = enc_r(5'd1, 5'd2, 5'd5, 5'd0, 6'h2A);
      mem[5]  = enc_r(5'd0, 5'd1, 5'd6, 5'd3, 6'h00);
      mem[6]  = enc_r(5'd0, 5'd4, 5'd7, 5'd28, 6'h02);
      mem[7]  = enc_i(6'h0C, 5'd4, 5'd8, 16'hF0F0);
      mem[8]  = enc_i(6'h0D, 5'd0, 5'd9, 16'h8001);
      mem[9]  = enc_i(6'h0A, 5'd4, 5'd10, 16'hFFFF);
      mem[10] = enc_r(5'd4, 5'd2, 5'd11, 5'd0, 6'h24);
      mem[11] = enc_r(5'd1, 5'd2, 5'd12, 5'd0, 6'h25);
      release_reset();
      tick(4);
      check("a_done1", 32'(instr_done), 32'd1);
      check("a_count1", instr_count, 32'd1);
      tick(1);
      check("a_done_pulse", 32'(instr_done), 32'd0);
      tick(7);
      check("a_count3", instr_count, 32'd3);
      check("a_r3", dut.u_rf.regs_q[3], 32'd12);
      check("a_pc", PC_out, 32'h0C);
      tick(36);
      check("a_count12", instr_count, 32'd12);
      check("a_sub", dut.u_rf.regs_q[4], 32'hFFFF_FFFE);
      check("a_slt", dut.u_rf.regs_q[5], 32'd1);
      check("a_sll", dut.u_rf.regs_q[6], 32'h28);
      check("a_srl", dut.u_rf.regs_q[7], 32'hF);
      check("a_andi", dut.u_rf.regs_q[8], 32'h0000_F0F0);
      check("a_ori", dut.u_rf.regs_q[9], 32'h0000_8001);
      check("a_slti", dut.u_rf.regs_q[10], 32'd1);
      check("a_and", dut.u_rf.regs_q[11], 32'd6);
      check("a_or", dut.u_rf.regs_q[12], 32'd7);

      // Store/load round trip, R0 write discard, fetch wait states
      hold_reset();
      mem[0]  = enc_i(6'h08, 5'd0, 5'd3, 16'd12);
      mem[1]  = enc_i(6'h08, 5'd0, 5'd0, 16'd1);
      mem[2]  = enc_i(6'h2B, 5'd0, 5'd3, 16'd8);
      mem[3]  = enc_i(6'h23, 5'd0, 5'd4, 16'd8);
      mem[4]  = enc_i(6'h23, 5'd0, 5'd6, 16'h0080);
      mem[32] = 32'hDEAD_BEEF;
      release_reset();
      tick(8);
      check("b_r0", dut.u_rf.regs_q[0], 32'h0);
      tick(4);
      check("b_nwrites", 32'(n_writes), 32'd1);
      check("b_waddr", last_waddr, 32'h8);
      check("b_wdata", last_wdata, 32'd12);
      check("b_sw_count", instr_count, 32'd3);
      tick(5);
      check("b_r4", dut.u_rf.regs_q[4], 32'd12);
      check("b_lw_count", instr_count, 32'd4);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         check("b_wait_req", 32'(mem_req), 32'd1);
         check("b_wait_addr", mem_addr, 32'h10);
         check("b_wait_state", 32'(state_out), 32'd0);
      end
      mem_ready = 1'b1;
      tick(4);
      check("b_lw_not_yet", instr_count, 32'd4);
      tick(1);
      check("b_lw_done", 32'(instr_done), 32'd1);
      check("b_lw_wait_count", instr_count, 32'd5);
      check("b_r6", dut.u_rf.regs_q[6], 32'hDEAD_BEEF);

      // Branches, jal, then illegal opcode halt
      hold_reset();
      mem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
      mem[1]  = enc_i(6'h05, 5'd2, 5'd0, 16'd6);
      mem[2]  = enc_i(6'h08, 5'd0, 5'd2, 16'd1);
      mem[3]  = enc_i(6'h08, 5'd0, 5'd5, 16'd3);
      mem[4]  = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFC);
      mem[8]  = enc_j(6'h03, 26'h10);
      mem[16] = 32'hFC00_0000;
      release_reset();
      tick(7);
      check("c_bne_untaken", PC_out, 32'h08);
      tick(11);
      check("c_beq_taken", PC_out, 32'h04);
      tick(3);
      check("c_bne_taken", PC_out, 32'h20);
      tick(3);
      check("c_jal_pc", PC_out, 32'h40);
      check("c_jal_r31", dut.u_rf.regs_q[31], 32'h24);
      check("c_count", instr_count, 32'd7);
      tick(2);
      check("c_halt_state", 32'(state_out), 32'd7);
      check("c_halted", 32'(halted), 32'd1);
      check("c_halt_req", 32'(mem_req), 32'd0);
      tick(10);
      check("c_halt_req_late", 32'(mem_req), 32'd0);
      check("c_halt_pc", PC_out, 32'h44);
      check("c_halt_count", instr_count, 32'd7);
      check("c_halt_state_late", 32'(state_out), 32'd7);

      // Misaligned load address and reset during a stalled MEM transfer
      hold_reset();
      mem[0] = enc_i(6'h23, 5'd0, 5'd1, 16'h0081);
      mem[32] = 32'h1234_5678;
      release_reset();
      tick(3);
      mem_ready = 1'b0;
      check("e_mem_state", 32'(state_out), 32'd3);
      check("e_misalign", mem_addr, 32'h80);
      tick(2);
      check("e_stall_req", 32'(mem_req), 32'd1);
      check("e_stall_we", 32'(mem_we), 32'd0);
      #2;
      reset_global = 1'b1;
      #1;
      check("e_rst_req", 32'(mem_req), 32'd0);
      check("e_rst_pc", PC_out, 32'h0);
      check("e_rst_state", 32'(state_out), 32'd0);
      check("e_rst_r1", dut.u_rf.regs_q[1], 32'h0);
      mem_ready = 1'b1;
      release_reset();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
